registerfile_param: RTL and testbench

- Parametrised successor to the single-cycle RISC-V register file: NUM_REGS x DATA_WIDTH storage, two asynchronous read ports, one synchronous write port.
- x0 is hard-wired to zero. The stack-pointer register has a configurable reset value.
- Adds a sequenced bulk-clear engine with a busy/done handshake, so the core can re-initialise architectural state without asserting global reset.
- Sits between the decode stage and the ALU/write-back mux in the single-cycle core.

---
 rtl/registerfile_param.sv | 146 ++++++++++++++
 tb/tb_registerfile_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/registerfile_param.sv
// registerfile_param: parametrised register file for the single-cycle core.
// It holds NUM_REGS x DATA_WIDTH registers, with two combinational read ports
// and one synchronous write port. x0 reads as zero. Register SP_INDEX resets
// and clears to SP_RESET_VALUE.
//
// A sequenced bulk-clear engine (IDLE -> CLEAR -> DONE) re-initialises every
// register, one per cycle, without a global reset. While the engine is busy,
// writes and new clear requests are dropped. Reads keep returning the current
// contents.
//
// Optional build macro: REGFILE_WRITE_BYPASS_EN. When it is defined, a read of
// the register being written in the same cycle returns writedata (same-cycle
// forwarding).
//
// Ports:
//   clk                       system clock, rising edge
//   reset                     asynchronous reset, active low
//   regwrite                  write enable (honoured only in IDLE)
//   writeregister/writedata   write index / write data
//   readregister1/2           read indices
//   readdata1/2               combinational read data
//   clear_req                 bulk-clear request (sampled only in IDLE)
//   clear_busy                high in CLEAR and DONE
//   clear_done                registered one-cycle pulse in DONE

// One storage element. The clear strobe loads the same value as reset.
module registerfile_param_cell #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_q <= RST_VAL;
    else if (i_clr) r_q <= RST_VAL;
    else if (i_we)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module registerfile_param #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_REGS       = 32,
  parameter int          SP_INDEX       = 2,
  parameter logic [31:0] SP_RESET_VALUE = 32'h7FFF_EFFC,
  localparam int         ADDR_WIDTH     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regwrite,
  input  logic [ADDR_WIDTH-1:0] writeregister,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [ADDR_WIDTH-1:0] readregister1,
  input  logic [ADDR_WIDTH-1:0] readregister2,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] readdata1,
  output logic [DATA_WIDTH-1:0] readdata2,
  output logic                  clear_busy,
  output logic                  clear_done
);
  // The stack-pointer value is truncated or zero-extended to the register width.
  localparam logic [DATA_WIDTH-1:0] SP_RST   = DATA_WIDTH'(SP_RESET_VALUE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_done;
  logic                  w_idle;
  logic                  w_wr_en;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;

  assign w_idle  = (r_state == S_IDLE);
  assign w_wr_en = regwrite && w_idle && (writeregister != '0);

  // x0 has no storage element.
  assign w_regs[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);

    registerfile_param_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VAL    ((gi == SP_INDEX) ? SP_RST : '0)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .i_we  (w_wr_en && (writeregister == IDX)),
      .i_clr ((r_state == S_CLEAR) && (r_idx == IDX)),
      .i_d   (writedata),
      .o_q   (w_regs[gi])
    );
  end

  // Clear sequencer: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear_req)          w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == LAST_IDX)  w_state_nxt = S_DONE;
      S_DONE:                          w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // The index stops at the last register rather than wrapping, because the
  // FSM leaves CLEAR on that same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= ADDR_WIDTH'(1);
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      if (w_idle && clear_req)
        r_idx <= ADDR_WIDTH'(1);
      else if ((r_state == S_CLEAR) && (r_idx != LAST_IDX))
        r_idx <= r_idx + 1'b1;
    end
  end

  assign clear_busy = !w_idle;
  assign clear_done = r_done;

  // Read ports
  always_comb begin
    readdata1 = w_regs[readregister1];
    readdata2 = w_regs[readregister2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // w_wr_en already excludes index 0, so x0 still reads zero.
    if (w_wr_en && (readregister1 == writeregister)) readdata1 = writedata;
    if (w_wr_en && (readregister2 == writeregister)) readdata2 = writedata;
`endif
  end
endmodule

// File: tb/tb_registerfile_param.sv
module tb_registerfile_param;
  localparam logic [31:0] SPV = 32'h7FFF_EFFC;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite;
  logic [4:0]  writeregister;
  logic [31:0] writedata;
  logic [4:0]  readregister1, readregister2;
  logic        clear_req;
  logic [31:0] readdata1, readdata2;
  logic        clear_busy, clear_done;

  registerfile_param #(
    .DATA_WIDTH(32), .NUM_REGS(32), .SP_INDEX(2), .SP_RESET_VALUE(SPV)
  ) dut (
    .clk(clk), .reset(reset), .regwrite(regwrite), .writeregister(writeregister),
    .writedata(writedata), .readregister1(readregister1), .readregister2(readregister2),
    .clear_req(clear_req), .readdata1(readdata1), .readdata2(readdata2),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e1, e2;
    logic        eb, ed;
  } sb_t;

  sb_t         sb_q[$];
  vec_t        tbl[10];
  logic [31:0] mdl[32];
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(string n, bit we, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] r1, logic [4:0] r2, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.name = n; v.we = we; v.wa = wa; v.wd = wd;
    v.ra1 = r1; v.ra2 = r2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb, input logic ed);
    sb_t s;
    s.name = nm; s.e1 = e1; s.e2 = e2; s.eb = eb; s.ed = ed;
    sb_q.push_back(s);
  endtask

  task automatic check_out();
    sb_t s;
    if (sb_q.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL sb_empty: got no expected entry required one");
    end else begin
      s = sb_q.pop_front();
      chk({s.name, ".rd1"}, readdata1, s.e1);
      chk({s.name, ".rd2"}, readdata2, s.e2);
      chk({s.name, ".busy"}, {31'b0, clear_busy}, {31'b0, s.eb});
      chk({s.name, ".done"}, {31'b0, clear_done}, {31'b0, s.ed});
    end
  endtask

  // Drive after the rising edge; sample on the falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 32; i++) begin
      step();
      regwrite = 1'b0; clear_req = 1'b0;
      readregister1 = 5'(i); readregister2 = 5'(31 - i);
      push($sformatf("%s_x%0d", tag, i), mdl[i], mdl[31 - i], 1'b0, 1'b0);
      @(negedge clk);
      check_out();
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    step();
    clear_req = 1'b0; regwrite = 1'b1;
    writeregister = 5'(idx); writedata = d;
    if (idx != 0) mdl[idx] = d;
  endtask

  int busy_cnt, done_cnt, done_at;
  bit ended;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; regwrite = 1'b0; writeregister = '0; writedata = '0;
    readregister1 = '0; readregister2 = '0; clear_req = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[2] = SPV;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, clear_busy}, 32'd0);
    chk("rst_done", {31'b0, clear_done}, 32'd0);
    reset = 1'b1;

    tbl[0] = mk("rst_x0_x2", 0, 0,  0,            0, 2, 0, SPV);
    tbl[1] = mk("rst_x5",    0, 0,  0,            5, 5, 0, 0);
    tbl[2] = mk("wr_x5",     1, 5,  32'hDEADBEEF, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 0);
    tbl[3] = mk("rd_x5_x5",  0, 0,  0,            5, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    tbl[4] = mk("wr_x0",     1, 0,  32'h1234,     0, 5, 0, 32'hDEADBEEF);
    tbl[5] = mk("x0_prot",   1, 7,  32'h00001111, 0, 0, 0, 0);
    tbl[6] = mk("byp_x7",    1, 7,  32'hA5A50001, 7, 5,
                BYP ? 32'hA5A50001 : 32'h00001111, 32'hDEADBEEF);
    tbl[7] = mk("rd_x7",     0, 0,  0,            7, 2, 32'hA5A50001, SPV);
    tbl[8] = mk("byp_x2",    1, 2,  32'hCAFE0002, 2, 1, BYP ? 32'hCAFE0002 : SPV, 0);
    tbl[9] = mk("rd_x2_x7",  0, 0,  0,            2, 7, 32'hCAFE0002, 32'hA5A50001);

    for (int i = 0; i < 10; i++) begin
      step();
      clear_req = 1'b0;
      regwrite = tbl[i].we; writeregister = tbl[i].wa; writedata = tbl[i].wd;
      readregister1 = tbl[i].ra1; readregister2 = tbl[i].ra2;
      push(tbl[i].name, tbl[i].e1, tbl[i].e2, 1'b0, 1'b0);
      @(negedge clk);
      check_out();
    end

    // Fill every register, then read all of them back
    for (int i = 1; i < 32; i++) wr(i, 32'h0000_0100 + 32'(i));
    readback("fill");

    // Bulk clear, with writes dropped in CLEAR and DONE and a stray request mid-clear
    step(); regwrite = 1'b0; clear_req = 1'b1;
    step(); clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; ended = 1'b0;
    for (int k = 0; k < 100 && !ended; k++) begin
      regwrite = (k == 3 || k == 31); writeregister = 5'd31; writedata = 32'hFFFF_FFFF;
      clear_req = (k == 5);
      @(negedge clk);
      if (clear_busy) busy_cnt++; else ended = 1'b1;
      if (clear_done) begin done_cnt++; done_at = busy_cnt; end
      step();
    end
    regwrite = 1'b0; clear_req = 1'b0;
    chk("clr_ended",    {31'b0, ended}, 32'd1);
    chk("clr_busy_cnt", busy_cnt, 32'd32);
    chk("clr_done_cnt", done_cnt, 32'd1);
    chk("clr_done_at",  done_at,  32'd32);
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clear_busy) busy_cnt++;
    end
    chk("no_extra_clear", busy_cnt, 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[2] = SPV;
    readback("clr");

    // Reset asserted in the tenth CLEAR cycle
    wr(5, 32'h55); wr(31, 32'h31); wr(2, 32'h2222);
    step(); regwrite = 1'b0; clear_req = 1'b1;
    step(); clear_req = 1'b0;
    repeat (9) step();
    chk("pre_rst_busy", {31'b0, clear_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, clear_busy}, 32'd0);
    chk("mid_rst_done", {31'b0, clear_done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
    end
    chk("post_rst_busy", busy_cnt, 32'd0);
    chk("post_rst_done", done_cnt, 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[2] = SPV;
    readback("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
